apple_placer: RTL and testbench

- Parametrised apple manager for the snake game. It holds NUM_APPLES apple slots on a 2^CW x 2^CW grid.
- On a rising edge of good_coll, it retires the apple under the snake head. It then re-places that apple using a sequential search that avoids every body segment, the head and the other live apples.
- It feeds the pixel renderer a registered per-pixel apple hit, and feeds game control busy, full and eaten indications.

---
 rtl/apple_placer.sv | 324 ++++++++++++++++++++++++++++++++
 tb/tb_apple_placer.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/apple_placer.sv
// -----------------------------------------------------------------------------
// apple_placer
//   Keeps NUM_APPLES apple slots on a 2^CW x 2^CW grid. A rising edge of
//   good_coll retires the lowest valid apple under the snake head. Each retired
//   or reset-pending slot is then re-placed by a sequential search. The search
//   starts from the random source and steps the candidate cell by one until it
//   finds a cell that is clear of every body segment, the head and the other
//   live apples.
//
// Ports
//   clk, reset (async, active low), s_reset (sync, active high game restart)
//   x, y             renderer pixel query; apple is the registered hit
//   head_x, head_y   snake head cell
//   rand_x, rand_y   free-running random start cell
//   good_coll        level, high while the head overlaps an apple
//   body, body_len   segment cells and number of valid segments
//   apple_valid      per-slot valid
//   apple_xy         per-slot cell {x,y}
//   busy             placement search running
//   board_full       sticky, a search found no free cell
//   eaten            one-cycle pulse when a slot is retired
//
// FSM
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_IDLE  | wait for a pending slot, latch the lowest one
//   S_LOAD  | seed candidate from the random source
//   S_SCAN  | compare candidate against one body segment per cycle
//   S_CHECK | compare candidate against head and other live apples
// -----------------------------------------------------------------------------
module apple_placer #(
    parameter int              CW         = 4,
    parameter int              MAX_LENGTH = 16,
    parameter int              NUM_APPLES = 2,
    parameter logic [2*CW-1:0] INIT_XY    = (2*CW)'(8'b1100_0101)
) (
    input  logic                                     clk,
    input  logic                                     reset,
    input  logic                                     s_reset,
    input  logic [CW-1:0]                            x,
    input  logic [CW-1:0]                            y,
    input  logic [CW-1:0]                            head_x,
    input  logic [CW-1:0]                            head_y,
    input  logic [CW-1:0]                            rand_x,
    input  logic [CW-1:0]                            rand_y,
    input  logic                                     good_coll,
    input  logic [MAX_LENGTH-1:0][2*CW-1:0]          body,
    input  logic [$clog2(MAX_LENGTH+1)-1:0]          body_len,
    output logic                                     apple,
    output logic [NUM_APPLES-1:0]                    apple_valid,
    output logic [NUM_APPLES-1:0][2*CW-1:0]          apple_xy,
    output logic                                     busy,
    output logic                                     board_full,
    output logic                                     eaten
);

    localparam int PW = 2 * CW;
    localparam int LW = $clog2(MAX_LENGTH + 1);
    localparam int SW = (NUM_APPLES > 1) ? $clog2(NUM_APPLES) : 1;
    localparam int TW = PW + 1;

    // Every cell of the grid has been tried once when tries hits 2^(2*CW).
    localparam logic [TW-1:0] TRIES_MAX = {1'b1, {PW{1'b0}}};

    localparam logic [NUM_APPLES-1:0]         VALID_RST = NUM_APPLES'(1);
    localparam logic [NUM_APPLES-1:0]         PEND_RST  = ~(NUM_APPLES'(1));
    localparam logic [NUM_APPLES*PW-1:0]      XY_RST    = (NUM_APPLES*PW)'(INIT_XY);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_SCAN  = 2'd2,
        S_CHECK = 2'd3
    } state_t;

    state_t                          state_q, state_d;
    logic [NUM_APPLES-1:0]           valid_q, valid_d;
    logic [NUM_APPLES-1:0][PW-1:0]   xy_q, xy_d;
    logic [NUM_APPLES-1:0]           pend_q, pend_d;
    logic [SW-1:0]                   sel_q, sel_d;
    logic [PW-1:0]                   cand_q, cand_d;
    logic [LW-1:0]                   idx_q, idx_d;
    logic [TW-1:0]                   tries_q, tries_d;
    logic                            full_q, full_d;
    logic                            eaten_q, eaten_d;
    logic                            apple_q, apple_d;
    logic                            gc_r0_q, gc_r1_q;

    logic [LW-1:0]                   len_eff;
    logic [PW-1:0]                   body_cur;
    logic                            scan_end;
    logic                            body_hit;
    logic                            check_hit;
    logic                            exhausted;
    logic                            any_pend;
    logic [SW-1:0]                   pend_sel;
    logic                            eat;
    logic                            eat_hit;
    logic [SW-1:0]                   eat_slot;
    logic [PW-1:0]                   head_xy;

    assign head_xy = {head_x, head_y};
    assign eat     = gc_r0_q & ~gc_r1_q;

    // -------------------------------------------------------------------------
    // Search and bookkeeping conditions
    // -------------------------------------------------------------------------
    always_comb begin
        len_eff = (body_len > LW'(MAX_LENGTH)) ? LW'(MAX_LENGTH) : body_len;

        // Segment mux; idx_q only reaches len_eff, which never selects a
        // segment because scan_end takes priority there.
        body_cur = '0;
        for (int i = 0; i < MAX_LENGTH; i++) begin
            if (idx_q == LW'(i)) begin
                body_cur = body[i];
            end
        end

        scan_end  = (idx_q == len_eff);
        body_hit  = (body_cur == cand_q);
        exhausted = (tries_q == TRIES_MAX);

        check_hit = (cand_q == head_xy);
        for (int i = 0; i < NUM_APPLES; i++) begin
            if (valid_q[i] && (SW'(i) != sel_q) && (xy_q[i] == cand_q)) begin
                check_hit = 1'b1;
            end
        end

        // Descending loops so the lowest index wins.
        any_pend = |pend_q;
        pend_sel = '0;
        for (int i = NUM_APPLES - 1; i >= 0; i--) begin
            if (pend_q[i]) begin
                pend_sel = SW'(i);
            end
        end

        eat_hit  = 1'b0;
        eat_slot = '0;
        for (int i = NUM_APPLES - 1; i >= 0; i--) begin
            if (eat && valid_q[i] && (xy_q[i] == head_xy)) begin
                eat_hit  = 1'b1;
                eat_slot = SW'(i);
            end
        end
    end

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else if (s_reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next state
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (any_pend) state_d = S_LOAD;
            end
            S_LOAD: begin
                state_d = S_SCAN;
            end
            S_SCAN: begin
                if (exhausted)     state_d = S_IDLE;
                else if (scan_end) state_d = S_CHECK;
            end
            S_CHECK: begin
                if (exhausted)      state_d = S_IDLE;
                else if (check_hit) state_d = S_SCAN;
                else                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: outputs
    // -------------------------------------------------------------------------
    always_comb begin
        busy = (state_q != S_IDLE);
    end

    // -------------------------------------------------------------------------
    // Datapath next state
    // -------------------------------------------------------------------------
    always_comb begin
        valid_d = valid_q;
        xy_d    = xy_q;
        pend_d  = pend_q;
        sel_d   = sel_q;
        cand_d  = cand_q;
        idx_d   = idx_q;
        tries_d = tries_q;
        full_d  = full_q;

        unique case (state_q)
            S_IDLE: begin
                if (any_pend) sel_d = pend_sel;
            end
            S_LOAD: begin
                cand_d  = {rand_x, rand_y};
                idx_d   = '0;
                tries_d = '0;
            end
            S_SCAN: begin
                if (exhausted) begin
                    full_d = 1'b1;
                    for (int i = 0; i < NUM_APPLES; i++) begin
                        if (SW'(i) == sel_q) pend_d[i] = 1'b0;
                    end
                end else if (!scan_end) begin
                    if (body_hit) begin
                        cand_d  = cand_q + PW'(1);
                        idx_d   = '0;
                        tries_d = tries_q + TW'(1);
                    end else begin
                        idx_d = idx_q + LW'(1);
                    end
                end
            end
            S_CHECK: begin
                if (exhausted) begin
                    full_d = 1'b1;
                    for (int i = 0; i < NUM_APPLES; i++) begin
                        if (SW'(i) == sel_q) pend_d[i] = 1'b0;
                    end
                end else if (check_hit) begin
                    cand_d  = cand_q + PW'(1);
                    idx_d   = '0;
                    tries_d = tries_q + TW'(1);
                end else begin
                    for (int i = 0; i < NUM_APPLES; i++) begin
                        if (SW'(i) == sel_q) begin
                            xy_d[i]    = cand_q;
                            valid_d[i] = 1'b1;
                            pend_d[i]  = 1'b0;
                        end
                    end
                end
            end
            default: ;
        endcase

        // Retiring only touches valid slots; the slot being placed is
        // pending and therefore invalid, so the two never collide.
        eaten_d = eat_hit;
        for (int i = 0; i < NUM_APPLES; i++) begin
            if (eat_hit && (SW'(i) == eat_slot)) begin
                valid_d[i] = 1'b0;
                pend_d[i]  = 1'b1;
            end
        end

        apple_d = 1'b0;
        for (int i = 0; i < NUM_APPLES; i++) begin
            if (valid_q[i] && (xy_q[i] == {x, y})) apple_d = 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // Datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= VALID_RST;
            xy_q    <= XY_RST;
            pend_q  <= PEND_RST;
            sel_q   <= '0;
            cand_q  <= '0;
            idx_q   <= '0;
            tries_q <= '0;
            full_q  <= 1'b0;
            eaten_q <= 1'b0;
            apple_q <= 1'b0;
            gc_r0_q <= 1'b0;
            gc_r1_q <= 1'b0;
        end else if (s_reset) begin
            valid_q <= VALID_RST;
            xy_q    <= XY_RST;
            pend_q  <= PEND_RST;
            sel_q   <= '0;
            cand_q  <= '0;
            idx_q   <= '0;
            tries_q <= '0;
            full_q  <= 1'b0;
            eaten_q <= 1'b0;
            apple_q <= 1'b0;
            gc_r0_q <= 1'b0;
            gc_r1_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
            xy_q    <= xy_d;
            pend_q  <= pend_d;
            sel_q   <= sel_d;
            cand_q  <= cand_d;
            idx_q   <= idx_d;
            tries_q <= tries_d;
            full_q  <= full_d;
            eaten_q <= eaten_d;
            apple_q <= apple_d;
            gc_r0_q <= good_coll;
            gc_r1_q <= gc_r0_q;
        end
    end

    assign apple       = apple_q;
    assign apple_valid = valid_q;
    assign apple_xy    = xy_q;
    assign board_full  = full_q;
    assign eaten       = eaten_q;

endmodule

// File: tb/tb_apple_placer.sv
// -----------------------------------------------------------------------------
// tb_apple_placer
//   Directed bench for apple_placer. Instance u_dut uses the default 16x16
//   grid with two slots; instance u_dut_b uses a 4x4 grid to reach the
//   full-board case.
// -----------------------------------------------------------------------------
module tb_apple_placer;

    localparam int CW = 4;
    localparam int PW = 8;
    localparam int ML = 16;
    localparam int NA = 2;
    localparam int LW = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance
    logic                  reset, s_reset, good_coll;
    logic [CW-1:0]         x, y, head_x, head_y, rand_x, rand_y;
    logic [ML-1:0][PW-1:0] body;
    logic [LW-1:0]         body_len;
    logic                  apple, busy, board_full, eaten;
    logic [NA-1:0]         apple_valid;
    logic [NA-1:0][PW-1:0] apple_xy;

    // Small-grid instance
    logic                  reset_b, s_reset_b, good_coll_b;
    logic [1:0]            x_b, y_b, head_x_b, head_y_b, rand_x_b, rand_y_b;
    logic [ML-1:0][3:0]    body_b;
    logic [LW-1:0]         body_len_b;
    logic                  apple_b, busy_b, board_full_b, eaten_b;
    logic [NA-1:0]         apple_valid_b;
    logic [NA-1:0][3:0]    apple_xy_b;

    apple_placer #(
        .CW(CW), .MAX_LENGTH(ML), .NUM_APPLES(NA), .INIT_XY(8'b1100_0101)
    ) u_dut (
        .clk(clk), .reset(reset), .s_reset(s_reset),
        .x(x), .y(y), .head_x(head_x), .head_y(head_y),
        .rand_x(rand_x), .rand_y(rand_y), .good_coll(good_coll),
        .body(body), .body_len(body_len),
        .apple(apple), .apple_valid(apple_valid), .apple_xy(apple_xy),
        .busy(busy), .board_full(board_full), .eaten(eaten)
    );

    apple_placer #(
        .CW(2), .MAX_LENGTH(ML), .NUM_APPLES(NA), .INIT_XY(4'b1001)
    ) u_dut_b (
        .clk(clk), .reset(reset_b), .s_reset(s_reset_b),
        .x(x_b), .y(y_b), .head_x(head_x_b), .head_y(head_y_b),
        .rand_x(rand_x_b), .rand_y(rand_y_b), .good_coll(good_coll_b),
        .body(body_b), .body_len(body_len_b),
        .apple(apple_b), .apple_valid(apple_valid_b), .apple_xy(apple_xy_b),
        .busy(busy_b), .board_full(board_full_b), .eaten(eaten_b)
    );

    int total = 0;
    int bad   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Raise good_coll with the head on an apple, hold it for at least 12
    // cycles, and follow the re-placement to completion.
    task automatic eat_place(input string tag, input logic [7:0] hd, input logic [7:0] hd_after,
                             input logic [7:0] rnd, input int slot, input logic [7:0] exp_xy,
                             input int exp_busy);
        int n_eat  = 0;
        int n_busy = 0;
        bit seen   = 1'b0;
        bit done   = 1'b0;
        {head_x, head_y} = hd;
        {rand_x, rand_y} = rnd;
        good_coll = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (done && i >= 12) break;
            tick();
            if (eaten) begin
                n_eat++;
                {head_x, head_y} = hd_after;
            end
            if (busy) begin
                seen = 1'b1;
                n_busy++;
            end else if (seen) begin
                done = 1'b1;
            end
        end
        check_eq({tag, " done"}, 32'(done), 32'd1);
        check_eq({tag, " eaten"}, 32'(n_eat), 32'd1);
        check_eq({tag, " busy cycles"}, 32'(n_busy), 32'(exp_busy));
        check_eq({tag, " valid"}, 32'(apple_valid), 32'h3);
        check_eq({tag, " xy"}, 32'(apple_xy[slot]), 32'(exp_xy));
        good_coll = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        int  n_eat;
        int  n_busy;
        bit  seen;
        bit  done;

        reset = 1'b0; s_reset = 1'b0; good_coll = 1'b0;
        x = '0; y = '0; head_x = '0; head_y = '0;
        rand_x = 4'd3; rand_y = 4'd3;
        body = '0; body_len = '0;

        reset_b = 1'b0; s_reset_b = 1'b0; good_coll_b = 1'b0;
        x_b = '0; y_b = '0; head_x_b = '0; head_y_b = '0;
        rand_x_b = 2'd0; rand_y_b = 2'd3;
        body_b = '0; body_len_b = 5'd15;
        begin
            int k = 0;
            for (int c = 0; c < 16; c++) begin
                if (c != 9) begin
                    body_b[k] = 4'(c);
                    k++;
                end
            end
        end

        repeat (2) @(posedge clk);
        #1;

        // Reset values
        check_eq("rst valid", 32'(apple_valid), 32'h1);
        check_eq("rst xy0", 32'(apple_xy[0]), 32'hC5);
        check_eq("rst xy1", 32'(apple_xy[1]), 32'h00);
        check_eq("rst busy", 32'(busy), 32'd0);
        check_eq("rst full", 32'(board_full), 32'd0);
        check_eq("rst eaten", 32'(eaten), 32'd0);
        check_eq("rst apple", 32'(apple), 32'd0);

        // Slot 1 auto placement at {3,3}; query slot 0 pixel meanwhile
        reset = 1'b1;
        tick();
        check_eq("init load busy", 32'(busy), 32'd1);
        check_eq("pix invalid slot", 32'(apple), 32'd0);
        x = 4'd12; y = 4'd5;
        tick();
        check_eq("pix c5", 32'(apple), 32'd1);
        check_eq("init scan valid", 32'(apple_valid), 32'h1);
        tick();
        check_eq("init check valid", 32'(apple_valid), 32'h1);
        tick();
        check_eq("init placed valid", 32'(apple_valid), 32'h3);
        check_eq("init placed xy1", 32'(apple_xy[1]), 32'h33);
        check_eq("init placed busy", 32'(busy), 32'd0);
        x = 4'd3; y = 4'd3;
        tick();
        check_eq("pix 33", 32'(apple), 32'd1);
        x = 4'd3; y = 4'd4;
        tick();
        check_eq("pix 34", 32'(apple), 32'd0);

        // Held good_coll on slot 0
        eat_place("eat held", 8'hC5, 8'hC5, 8'h77, 0, 8'h77, 3);

        // good_coll edge with no apple under the head
        head_x = 4'd1; head_y = 4'd1;
        good_coll = 1'b1;
        n_eat = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (eaten) n_eat++;
        end
        check_eq("nomatch eaten", 32'(n_eat), 32'd0);
        check_eq("nomatch valid", 32'(apple_valid), 32'h3);
        good_coll = 1'b0;
        tick();
        tick();

        // Body avoidance: 22 -> 23 -> 24
        body[0] = 8'h22; body[1] = 8'h23; body[2] = 8'h99;
        body_len = 5'd3;
        eat_place("body", 8'h33, 8'h33, 8'h22, 1, 8'h24, 9);

        // Move slot 1 to {0,0}, then wrap from {15,15} past head and slot 1
        body_len = 5'd0;
        eat_place("slot1 zero", 8'h24, 8'h24, 8'h00, 1, 8'h00, 3);
        eat_place("wrap", 8'h77, 8'hFF, 8'hFF, 0, 8'h01, 7);
        check_eq("wrap full", 32'(board_full), 32'd0);

        // s_reset mid-SCAN, then re-place with an over-range body_len
        for (int i = 0; i < ML; i++) body[i] = 8'hEE;
        body_len = 5'd20;
        head_x = 4'd0; head_y = 4'd0;
        rand_x = 4'd5; rand_y = 4'd5;
        good_coll = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (seen) break;
            tick();
            if (busy) seen = 1'b1;
        end
        check_eq("srst search started", 32'(seen), 32'd1);
        repeat (3) tick();
        check_eq("srst mid busy", 32'(busy), 32'd1);
        s_reset = 1'b1;
        good_coll = 1'b0;
        tick();
        s_reset = 1'b0;
        check_eq("srst busy", 32'(busy), 32'd0);
        check_eq("srst valid", 32'(apple_valid), 32'h1);
        check_eq("srst xy0", 32'(apple_xy[0]), 32'hC5);
        check_eq("srst xy1", 32'(apple_xy[1]), 32'h00);
        check_eq("srst full", 32'(board_full), 32'd0);
        check_eq("srst eaten", 32'(eaten), 32'd0);
        check_eq("srst apple", 32'(apple), 32'd0);
        n_busy = 0; seen = 1'b0; done = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (done) break;
            tick();
            if (busy) begin
                seen = 1'b1;
                n_busy++;
            end else if (seen) begin
                done = 1'b1;
            end
        end
        check_eq("clamp done", 32'(done), 32'd1);
        check_eq("clamp busy cycles", 32'(n_busy), 32'd19);
        check_eq("clamp valid", 32'(apple_valid), 32'h3);
        check_eq("clamp xy1", 32'(apple_xy[1]), 32'h55);

        // Full board on the 4x4 grid: body covers 15 cells, slot 0 the 16th
        reset_b = 1'b1;
        repeat (5) tick();
        check_eq("full early busy", 32'(busy_b), 32'd1);
        check_eq("full early flag", 32'(board_full_b), 32'd0);
        done = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            if (done) break;
            tick();
            if (!busy_b) done = 1'b1;
        end
        check_eq("full done", 32'(done), 32'd1);
        check_eq("full flag", 32'(board_full_b), 32'd1);
        check_eq("full valid", 32'(apple_valid_b), 32'h1);
        check_eq("full xy0", 32'(apple_xy_b[0]), 32'h9);
        repeat (3) tick();
        check_eq("full sticky", 32'(board_full_b), 32'd1);
        check_eq("full idle", 32'(busy_b), 32'd0);
        s_reset_b = 1'b1;
        tick();
        s_reset_b = 1'b0;
        check_eq("full srst flag", 32'(board_full_b), 32'd0);
        check_eq("full srst valid", 32'(apple_valid_b), 32'h1);

        check_eq("main full", 32'(board_full), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
